pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the IF stage of the MIPS pipeline. It replaces the bare PC increment with these functions:
- a registered PC with a boot vector;
- stall hold and a valid/ready handshake to instruction memory;
- prioritised exception, branch and jump redirects;
- a one-entry pending-redirect buffer, so a redirect arriving while a fetch is outstanding is not lost.

## Interface
Parameters:
- XLEN, 32, PC width in bits.
- INC, 4, sequential increment; power of two, ≥1.
- RESET_VEC, 32'h0000_0000, PC value after reset.
- EXC_VEC, 32'h8000_0180, exception handler address.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard-unit stall; holds the PC.
- exc_i  in  1  exception redirect to EXC_VEC.
- branch_i  in  1  taken-branch redirect.
- branch_tgt_i  in  XLEN  branch target.
- jump_i  in  1  jump redirect.
- jump_tgt_i  in  XLEN  jump target.
- if_ready_i  in  1  instruction memory accepts pc_o.
- pc_valid_o  out  1  pc_o is a valid fetch request.
- pc_o  out  XLEN  current fetch address.
- pc_plus_o  out  XLEN  pc_o + INC, used for link registers.
- pend_o  out  1  redirect is buffered; the current fetch is wrong-path.
- misalign_o  out  1  pc_o is not INC-aligned; see Configuration.

## Operation
Terms:
- fire = pc_valid_o & if_ready_i.
- pc_valid_o = (state != BOOT) & ~stall_i. This is combinational from state and stall_i.
- redir = exc_i | branch_i | jump_i.
- Redirect target priority: exc_i (EXC_VEC), then branch_i, then jump_i.

States:
- BOOT: entered on reset. pc_o = RESET_VEC, pc_valid_o = 0. Moves to RUN unconditionally on the next edge.
- RUN:
  - redir with pc_valid_o & ~if_ready_i: pend_pc ← target, go to PEND, pc_o unchanged.
  - redir otherwise: pc ← target, stay in RUN.
  - no redir, fire: pc ← pc + INC.
  - else: hold.
- PEND: pend_o = 1.
  - redir in the same cycle overwrites pend_pc. Newest redirect wins.
  - on fire or ~pc_valid_o: pc ← (redir ? target : pend_pc), go to RUN.
  - a fire in PEND delivers a wrong-path instruction; the decoder squashes it using the registered pend_o.
  - else: hold.

Common rules:
- Handshake rule: while pc_valid_o & ~if_ready_i, pc_o is stable.
- Arithmetic: pc + INC wraps modulo 2^XLEN. pc_plus_o is combinational, with the same wrap.
- Stall with no redir holds the PC. Stall with redir in RUN loads the target directly, because pc_valid_o is 0.

## Timing
- Outputs at reset:
  - pc_o = RESET_VEC
  - pc_valid_o = 0
  - pend_o = 0
  - misalign_o = 0
  - pend_pc = 0
- pc_valid_o first rises one cycle after rst_n deasserts.
- Redirect latency: the target appears on pc_o the cycle after redir is sampled, unless it is buffered in PEND.
- Sequential fetch rate is one per cycle while if_ready_i = 1 and stall_i = 0.
- Reset asserted mid-operation: asynchronously clears the PC, the pending buffer and the state. The pending redirect is discarded.
- stall_i and if_ready_i may both toggle in any cycle. stall_i takes precedence over fire.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - redirect targets load unmodified;
  - misalign_o is registered with the PC and is 1 while pc_o[log2(INC)-1:0] != 0;
  - the PC still increments by INC.
- PC_ALIGN_CHECK_EN undefined:
  - the low log2(INC) target bits are forced to 0;
  - misalign_o is tied to 0.
- With INC = 1 there are no low bits to check, so misalign_o is always 0 in both builds.

## Structure
- Shared package pc_pkg holds:
  - the state enum (BOOT, RUN, PEND);
  - the redirect-source enum (NONE, EXC, BR, JMP);
  - default constants for XLEN, INC, RESET_VEC and EXC_VEC.
- Sub-module pc_redirect_arb: combinational priority mux producing redir and the target. The alignment mask is applied here.

## Test plan
- Reset release, if_ready_i = 1: pc_valid_o goes 0→1 after one cycle. pc_o steps 0x0, 0x4, 0x8, 0xC, with pc_plus_o = pc_o + 4.
- Hold then redirect: pc_o = 0x10 held by if_ready_i = 0 while branch_i = 1, branch_tgt_i = 0x400.
  - pend_o = 1 and pc_o stays 0x10.
  - When if_ready_i = 1, pc_o becomes 0x400 next cycle and pend_o = 0.
- Same-cycle conflict: exc_i, branch_i and jump_i all high. The next pc_o is 0x8000_0180.
- Wrap-around: XLEN = 8, pc_o = 0xFC, fire. The next pc_o is 0x00.
- Stall: stall_i = 1 for 3 cycles. pc_valid_o = 0 and pc_o is constant. A jump_i with target 0x200 during the stall gives pc_o = 0x200 next cycle.
- Alignment, jump target 0x102:
  - with PC_ALIGN_CHECK_EN: pc_o = 0x102 and misalign_o = 1;
  - without it: pc_o = 0x100 and misalign_o = 0.
  - Async reset mid-PEND returns all outputs to their reset values immediately.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default constants for the IF-stage program-counter generator.
// Used by pc_gen and pc_redirect_arb.
package pc_pkg;

    localparam int          DEF_XLEN      = 32;
    localparam int          DEF_INC       = 4;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0180;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EXC  = 2'd1,
        BR   = 2'd2,
        JMP  = 2'd3
    } redir_src_e;

endpackage

// File: rtl/pc_redirect_arb.sv
// Priority mux for exception, branch and jump redirects (exception highest).
// Build option PC_ALIGN_CHECK_EN: when undefined, low target bits are forced to zero.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int              XLEN    = DEF_XLEN,
    parameter int              INC     = DEF_INC,
    parameter logic [XLEN-1:0] EXC_VEC = XLEN'(DEF_EXC_VEC)
) (
    input  logic            exc_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_tgt_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_tgt_i,
    output logic            redir_o,
    output logic [XLEN-1:0] target_o
);

    redir_src_e      src;
    logic [XLEN-1:0] raw_tgt;

    always_comb begin
        src = NONE;
        if (exc_i) begin
            src = EXC;
        end else if (branch_i) begin
            src = BR;
        end else if (jump_i) begin
            src = JMP;
        end
    end

    always_comb begin
        raw_tgt = '0;
        unique case (src)
            EXC:     raw_tgt = EXC_VEC;
            BR:      raw_tgt = branch_tgt_i;
            JMP:     raw_tgt = jump_tgt_i;
            default: raw_tgt = '0;
        endcase
    end

    assign redir_o = (src != NONE);

`ifdef PC_ALIGN_CHECK_EN
    assign target_o = raw_tgt;
`else
    // With INC = 1 the mask is all ones and targets pass through untouched.
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INC - 1);
    assign target_o = raw_tgt & ~LOW_MASK;
`endif

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot vector, stall hold, fetch handshake and one pending redirect.
// Build option PC_ALIGN_CHECK_EN keeps targets unmodified and reports misalignment on misalign_o.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = DEF_XLEN,
    parameter int              INC       = DEF_INC,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEF_EXC_VEC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            exc_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_tgt_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_tgt_i,
    input  logic            if_ready_i,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            pend_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            redir;
    logic [XLEN-1:0] target;
    logic            fire;

    pc_redirect_arb #(
        .XLEN    (XLEN),
        .INC     (INC),
        .EXC_VEC (EXC_VEC)
    ) u_arb (
        .exc_i        (exc_i),
        .branch_i     (branch_i),
        .branch_tgt_i (branch_tgt_i),
        .jump_i       (jump_i),
        .jump_tgt_i   (jump_tgt_i),
        .redir_o      (redir),
        .target_o     (target)
    );

    assign pc_valid_o = (state_q != BOOT) & ~stall_i;
    assign fire       = pc_valid_o & if_ready_i;

    // A redirect that cannot be taken because the fetch is stuck waiting is parked in pend_pc.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redir && pc_valid_o && !if_ready_i) begin
                    pend_pc_d = target;
                    state_d   = PEND;
                end else if (redir) begin
                    pc_d = target;
                end else if (fire) begin
                    pc_d = pc_q + INC_V;
                end
            end
            PEND: begin
                if (redir) begin
                    pend_pc_d = target;
                end
                if (fire || !pc_valid_o) begin
                    pc_d    = redir ? target : pend_pc_q;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VEC;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_plus_o = pc_q + INC_V;
    assign pend_o    = (state_q == PEND);

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INC - 1);

    logic misalign_q;

    // Tracks the PC register so the flag lines up with the address it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= |(pc_d & LOW_MASK);
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios, randomized traffic against a reference model,
// and an 8-bit instance for address wrap-around.
module tb_pc_gen;

    localparam logic [31:0] EXC_ADDR = 32'h8000_0180;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [31:0] EXP_ALIGN_PC  = 32'h0000_0102;
    localparam logic [31:0] EXP_ALIGN_MIS = 32'd1;
`else
    localparam logic [31:0] EXP_ALIGN_PC  = 32'h0000_0100;
    localparam logic [31:0] EXP_ALIGN_MIS = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        exc = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branchTgt = '0;
    logic        jump = 1'b0;
    logic [31:0] jumpTgt = '0;
    logic        ifReady = 1'b1;
    logic        pcValid;
    logic [31:0] pc;
    logic [31:0] pcPlus;
    logic        pend;
    logic        misalign;

    logic        rstW_n = 1'b0;
    logic        wValid;
    logic [7:0]  wPc;
    logic [7:0]  wPlus;
    logic        wPend;
    logic        wMis;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model state: the address being fetched and any parked redirect.
    logic        mBooted;
    logic [31:0] mPc;
    logic        mPending;
    logic [31:0] mPendTgt;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall),
        .exc_i        (exc),
        .branch_i     (branch),
        .branch_tgt_i (branchTgt),
        .jump_i       (jump),
        .jump_tgt_i   (jumpTgt),
        .if_ready_i   (ifReady),
        .pc_valid_o   (pcValid),
        .pc_o         (pc),
        .pc_plus_o    (pcPlus),
        .pend_o       (pend),
        .misalign_o   (misalign)
    );

    pc_gen #(
        .XLEN      (8),
        .INC       (4),
        .RESET_VEC (8'hF0),
        .EXC_VEC   (8'h80)
    ) dutWrap (
        .clk          (clk),
        .rst_n        (rstW_n),
        .stall_i      (1'b0),
        .exc_i        (1'b0),
        .branch_i     (1'b0),
        .branch_tgt_i (8'h00),
        .jump_i       (1'b0),
        .jump_tgt_i   (8'h00),
        .if_ready_i   (1'b1),
        .pc_valid_o   (wValid),
        .pc_o         (wPc),
        .pc_plus_o    (wPlus),
        .pend_o       (wPend),
        .misalign_o   (wMis)
    );

    function automatic logic anyRedirect();
        return exc | branch | jump;
    endfunction

    function automatic logic [31:0] pickTarget();
        logic [31:0] t;
        t = exc ? EXC_ADDR : (branch ? branchTgt : jumpTgt);
`ifdef PC_ALIGN_CHECK_EN
        return t;
`else
        return t & ~32'h3;
`endif
    endfunction

    function automatic logic [31:0] expMisalign();
`ifdef PC_ALIGN_CHECK_EN
        return {31'd0, |mPc[1:0]};
`else
        return 32'd0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBooted  <= 1'b0;
            mPc      <= 32'h0;
            mPending <= 1'b0;
            mPendTgt <= 32'h0;
        end else if (!mBooted) begin
            mBooted <= 1'b1;
        end else if (!mPending) begin
            if (anyRedirect() && !stall && !ifReady) begin
                mPending <= 1'b1;
                mPendTgt <= pickTarget();
            end else if (anyRedirect()) begin
                mPc <= pickTarget();
            end else if (!stall && ifReady) begin
                mPc <= mPc + 32'd4;
            end
        end else begin
            if (stall || ifReady) begin
                mPc      <= anyRedirect() ? pickTarget() : mPendTgt;
                mPending <= 1'b0;
            end else if (anyRedirect()) begin
                mPendTgt <= pickTarget();
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkModel();
        checkOutput("model_valid", 32'(pcValid), 32'(mBooted && !stall));
        checkOutput("model_pc", pc, mPc);
        checkOutput("model_pc_plus", pcPlus, mPc + 32'd4);
        checkOutput("model_pend", 32'(pend), 32'(mPending));
        checkOutput("model_misalign", 32'(misalign), expMisalign());
    endtask

    task automatic applyStimulus(input logic s, input logic e, input logic b, input logic [31:0] bt,
                                 input logic j, input logic [31:0] jt, input logic r);
        @(negedge clk);
        stall     = s;
        exc       = e;
        branch    = b;
        branchTgt = bt;
        jump      = j;
        jumpTgt   = jt;
        ifReady   = r;
        #1;
        checkModel();
    endtask

    initial begin
        logic [7:0] wrapSeq [5];
        wrapSeq = '{8'hF0, 8'hF4, 8'hF8, 8'hFC, 8'h00};

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_valid", 32'(pcValid), 32'd0);
        checkOutput("reset_pend", 32'(pend), 32'd0);
        checkOutput("reset_misalign", 32'(misalign), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("boot_valid", 32'(pcValid), 32'd0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("seq_valid", 32'(pcValid), 32'd1);
        checkOutput("seq_pc0", pc, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("seq_pc1", pc, 32'h4);
        checkOutput("seq_plus1", pcPlus, 32'h8);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("seq_pc2", pc, 32'h8);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("seq_pc3", pc, 32'hC);

        applyStimulus(0, 0, 1, 32'h400, 0, 0, 0);
        checkOutput("hold_pc", pc, 32'h10);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("pend_set", 32'(pend), 32'd1);
        checkOutput("pend_pc_stable", pc, 32'h10);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("pend_fire_pc", pc, 32'h10);

        applyStimulus(0, 1, 1, 32'h800, 1, 32'h900, 1);
        checkOutput("pend_released_pc", pc, 32'h400);
        checkOutput("pend_cleared", 32'(pend), 32'd0);

        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("priority_exc", pc, EXC_ADDR);
        checkOutput("stall_valid", 32'(pcValid), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("stall_hold", pc, EXC_ADDR);
        applyStimulus(1, 0, 0, 0, 1, 32'h200, 1);
        checkOutput("stall_hold2", pc, EXC_ADDR);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("stall_jump", pc, 32'h200);

        applyStimulus(0, 0, 0, 0, 1, 32'h102, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("align_pc", pc, EXP_ALIGN_PC);
        checkOutput("align_misalign", 32'(misalign), EXP_ALIGN_MIS);
        applyStimulus(0, 0, 1, 32'h300, 0, 0, 1);

        applyStimulus(0, 0, 1, 32'h500, 0, 0, 0);
        checkOutput("pre_reset_pc", pc, 32'h300);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("pre_reset_pend", 32'(pend), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_pc", pc, 32'h0);
        checkOutput("async_valid", 32'(pcValid), 32'd0);
        checkOutput("async_pend", 32'(pend), 32'd0);
        checkOutput("async_misalign", 32'(misalign), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            logic [31:0] bt;
            logic [31:0] jt;
            bt = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & ~32'h3);
            jt = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & ~32'h3);
            applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 5) == 0, bt, $urandom_range(0, 5) == 0, jt,
                          $urandom_range(0, 2) != 0);
        end

        @(negedge clk);
        rstW_n = 1'b1;
        #1;
        checkOutput("wrap_boot_valid", 32'(wValid), 32'd0);
        checkOutput("wrap_boot_pc", 32'(wPc), 32'hF0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            checkOutput("wrap_pc", 32'(wPc), 32'(wrapSeq[k]));
            checkOutput("wrap_valid", 32'(wValid), 32'd1);
        end
        checkOutput("wrap_plus", 32'(wPlus), 32'h04);
        checkOutput("wrap_pend", 32'(wPend), 32'd0);
        checkOutput("wrap_misalign", 32'(wMis), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
